// File: rtl/req_dispatch_4wr.sv
// -----------------------------------------------------------------------------
// req_dispatch_4wr
//
// Front-end dispatcher for the 4-way response sequencer. It takes requests from
// one master and decodes the target slave from two address bits. Each request
// is forwarded to that slave with a req/ack handshake. Every read also pushes
// the slave index as a tag into the sequencer's tag FIFO. A credit counter
// limits in-flight reads to the depth of the sequencer's reorder buffer.
//
// Ports
//   clk_i, rst_i            clock (rising edge) / async active-low reset
//   m_req_i, m_we_i         master request valid / write(1) or read(0)
//   m_addr_bi, m_wdata_bi   master address / write data
//   m_ack_o                 same-cycle pulse: request taken (IDLE only)
//   s_req_o                 one-hot slave request, held until its ack
//   s_we_o, s_addr_bo,
//   s_wdata_bo              registered request fields towards the slaves
//   s_ack_bi                per-slave accept; only the selected bit is used
//   tag_fifo_full_i         sequencer tag FIFO full
//   tag_fifo_wrreq_o        one-cycle tag push strobe (reads only)
//   tag_fifo_wdata_bo       pushed tag = target slave index
//   seq_wr_i                sequencer delivered a response; returns one credit
//   outstanding_bo          reads in flight (0..MAX_OUTSTANDING)
//   busy_o                  FSM is in ISSUE
//   err_o                   sticky: seq_wr_i arrived with no read in flight
// -----------------------------------------------------------------------------
module req_dispatch_4wr #(
  parameter int TAG_WIDTH       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SEL_LSB         = 30,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m_req_i,
  input  logic                  m_we_i,
  input  logic [ADDR_WIDTH-1:0] m_addr_bi,
  input  logic [DATA_WIDTH-1:0] m_wdata_bi,
  output logic                  m_ack_o,
  output logic [3:0]            s_req_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_bo,
  output logic [DATA_WIDTH-1:0] s_wdata_bo,
  input  logic [3:0]            s_ack_bi,
  input  logic                  tag_fifo_full_i,
  output logic                  tag_fifo_wrreq_o,
  output logic [TAG_WIDTH-1:0]  tag_fifo_wdata_bo,
  input  logic                  seq_wr_i,
  output logic [2:0]            outstanding_bo,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               state_q;
  logic [TAG_WIDTH-1:0] sel;
  logic [TAG_WIDTH-1:0] sel_q;
  logic                 credit_ok;
  logic                 eligible;
  logic                 rd_accept;
  logic                 credit_free;

  assign sel = m_addr_bi[SEL_LSB+TAG_WIDTH-1:SEL_LSB];

  // Eligibility uses the registered count, so a credit returned by seq_wr_i
  // only becomes usable in the following cycle.
  assign credit_ok = (outstanding_bo < 3'(MAX_OUTSTANDING)) && !tag_fifo_full_i;
  assign eligible  = (state_q == IDLE) && m_req_i && (m_we_i || credit_ok);

  // NOTE: IDLE is also the reset state, so without the rst_i term the master
  // could see an ack while reset is still held.
  assign m_ack_o   = eligible && rst_i;

  assign rd_accept   = eligible && !m_we_i;
  // A response with nothing in flight is an error and returns no credit.
  assign credit_free = seq_wr_i && (outstanding_bo != 3'd0);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q           <= IDLE;
      sel_q             <= '0;
      s_req_o           <= '0;
      s_we_o            <= 1'b0;
      s_addr_bo         <= '0;
      s_wdata_bo        <= '0;
      tag_fifo_wrreq_o  <= 1'b0;
      tag_fifo_wdata_bo <= '0;
      outstanding_bo    <= '0;
      busy_o            <= 1'b0;
      err_o             <= 1'b0;
    end else begin
      // The tag strobe is a single-cycle pulse unless re-armed below.
      tag_fifo_wrreq_o <= 1'b0;

      case (state_q)
        IDLE: begin
          if (eligible) begin
            state_q    <= ISSUE;
            busy_o     <= 1'b1;
            sel_q      <= sel;
            s_req_o    <= 4'b0001 << sel;
            s_we_o     <= m_we_i;
            s_addr_bo  <= m_addr_bi;
            s_wdata_bo <= m_wdata_bi;
            // The FIFO was sampled not-full this cycle and nothing else
            // pushes, so pushing one cycle later cannot overflow it.
            if (!m_we_i) begin
              tag_fifo_wrreq_o  <= 1'b1;
              tag_fifo_wdata_bo <= sel;
            end
          end
        end
        ISSUE: begin
          if (s_ack_bi[sel_q]) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            s_req_o <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          s_req_o <= '0;
        end
      endcase

      // Simultaneous accept and release cancel out. Increment cannot pass
      // MAX_OUTSTANDING because rd_accept requires a free credit.
      case ({rd_accept, credit_free})
        2'b10:   outstanding_bo <= outstanding_bo + 3'd1;
        2'b01:   outstanding_bo <= outstanding_bo - 3'd1;
        default: outstanding_bo <= outstanding_bo;
      endcase

      if (seq_wr_i && (outstanding_bo == 3'd0)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/req_dispatch_4wr.md
# req_dispatch_4wr

Front-end dispatcher for the 4-way response sequencer: it accepts requests from a single master and decodes the target slave (0..3) from address bits. It forwards each request to that slave port with a req/ack handshake and pushes the slave index as a tag into the sequencer's tag FIFO for every read. An outstanding-read credit counter keeps in-flight reads within the sequencer's 4-entry reorder buffer, so the sequencer never overflows.

## Interface
- TAG_WIDTH, 2, slave-index/tag width; fixed at 2 for 4 slaves
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, write-data width
- SEL_LSB, 30, slave select = m_addr_bi[SEL_LSB+1:SEL_LSB]
- MAX_OUTSTANDING, 4, read credits; must equal sequencer buffer depth
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- m_req_i  in  1  master request valid, held until m_ack_o
- m_we_i  in  1  1 = write, 0 = read
- m_addr_bi  in  ADDR_WIDTH  request address
- m_wdata_bi  in  DATA_WIDTH  write data
- m_ack_o  out  1  one-cycle pulse: request taken
- s_req_o  out  4  one-hot slave request, held until matching s_ack_bi bit
- s_we_o  out  1  registered write enable to slaves
- s_addr_bo  out  ADDR_WIDTH  registered address to slaves
- s_wdata_bo  out  DATA_WIDTH  registered write data to slaves
- s_ack_bi  in  4  per-slave accept
- tag_fifo_full_i  in  1  sequencer tag FIFO full
- tag_fifo_wrreq_o  out  1  tag push strobe
- tag_fifo_wdata_bo  out  TAG_WIDTH  tag = target slave index
- seq_wr_i  in  1  sequencer delivered one response; frees one credit
- outstanding_bo  out  3  current reads in flight (0..MAX_OUTSTANDING)
- busy_o  out  1  FSM in ISSUE
- err_o  out  1  sticky: seq_wr_i seen with outstanding_bo == 0

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: the request is eligible when m_req_i = 1 and either:
  - m_we_i = 1, or
  - outstanding_bo < MAX_OUTSTANDING and tag_fifo_full_i = 0.
- IDLE, eligible:
  - m_ack_o = 1 combinationally in the same cycle.
  - Latch we/addr/wdata and sel into output registers; go to ISSUE.
  - Reads only: register tag_fifo_wrreq_o = 1 and tag_fifo_wdata_bo = sel for the next cycle, and increment outstanding.
- IDLE, not eligible: m_ack_o = 0; the master holds its request.
- ISSUE: s_req_o[sel] = 1, all other bits 0; s_* outputs stable. On s_ack_bi[sel] = 1, go to IDLE next cycle. s_ack_bi bits other than sel are ignored.
- Writes push no tag and consume no credit.
- outstanding update:
  - +1 on read accept, −1 on seq_wr_i.
  - Both in the same cycle: unchanged.
  - seq_wr_i at 0: stays 0, err_o set.
  - Never exceeds MAX_OUTSTANDING.
- A credit freed by seq_wr_i is usable from the following cycle; eligibility uses the registered count.
- tag_fifo_full_i is sampled in IDLE only. The push one cycle later is safe because no other pusher exists.

## Timing
- Reset (rst_i = 0, async): state IDLE, and all of these are 0 immediately: s_req_o, s_we_o, s_addr_bo, s_wdata_bo, tag_fifo_wrreq_o, tag_fifo_wdata_bo, outstanding_bo, busy_o, err_o. m_ack_o is 0 while reset is held.
- Reset mid-ISSUE: the request is dropped with no ack to the master and no tag pushed afterwards.
- Accept in cycle T:
  - T+1: s_req_o valid, busy_o = 1, tag_fifo_wrreq_o pulse (reads), outstanding_bo updated.
  - s_ack_bi[sel] in cycle T+k (k ≥ 1, may be T+1): state IDLE at T+k+1.
  - Next accept possible at T+k+1, so peak rate is 1 request per 2 cycles.
- tag_fifo_wrreq_o is exactly one cycle wide per read; tags enter the FIFO in accept order.
- m_ack_o is never asserted in ISSUE.

## Test plan
- Single read, addr 0x8000_0000 (sel 2), s_ack_bi[2] in T+1:
  - m_ack_o at T.
  - s_req_o = 4'b0100 at T+1.
  - tag_fifo_wrreq_o = 1 with tag 2 at T+1.
  - outstanding_bo = 1 from T+1.
- Five back-to-back reads to slaves 0,1,2,3,0 with immediate acks and no seq_wr_i:
  - 4 accepted; tags 0,1,2,3 pushed in order.
  - 5th held with m_ack_o = 0.
  - One seq_wr_i pulse, then 5th accepted the next cycle with tag 0.
- Write to slave 1 with outstanding_bo = 4:
  - accepted anyway.
  - no tag push; outstanding_bo stays 4.
- Read accept and seq_wr_i in the same cycle at outstanding_bo = 2: outstanding_bo remains 2.
- tag_fifo_full_i = 1 with credits free: read stalls; write to slave 3 is accepted.
- seq_wr_i at outstanding_bo = 0: err_o = 1 and stays set until reset.
- Reset during ISSUE with s_req_o = 4'b0010: s_req_o = 0 immediately; after reset, outstanding_bo = 0 and state IDLE.
